// File: rtl/svf_voice_scheduler.sv
// Frame scheduler that time-multiplexes the 8-slot shared state-variable filter across 8 voices.
// Each tick snapshots the voice inputs and walks the enabled voices in 5-cycle filter slots.
module svf_voice_scheduler (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sample_tick,
  input  logic [95:0] voice_in,
  input  logic [7:0]  voice_en,
  input  logic        cfg_we,
  input  logic [2:0]  cfg_addr,
  input  logic [17:0] cfg_f,
  input  logic [17:0] cfg_q,
  input  logic        clear_stb,
  input  logic [7:0]  clear_mask,
  input  logic        overrun_clr,
  output logic        svf_ena,
  output logic [2:0]  svf_sel,
  output logic [17:0] svf_f,
  output logic [17:0] svf_q,
  output logic [11:0] svf_in,
  output logic        svf_reset,
  input  logic [17:0] svf_out,
  output logic        out_valid,
  output logic [2:0]  out_voice,
  output logic [17:0] out_data,
  output logic        frame_done,
  output logic        busy,
  output logic        overrun
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, CAPTURE} state_t;

  state_t      state, state_nxt;
  logic [1:0]  wait_cnt;
  logic [7:0]  mask;
  logic [7:0]  clear_pending;
  logic [7:0]  above;
  logic [7:0]  cap_clr;
  logic [95:0] buffer;
  logic [17:0] tbl_f [8];
  logic [17:0] tbl_q [8];

  logic        start_frame;
  logic        empty_frame;
  logic        issue_next;
  logic        capture;
  logic        tick_found;
  logic        next_found;
  logic [2:0]  tick_idx;
  logic [2:0]  next_idx;
  logic [2:0]  issue_v;
  logic [6:0]  issue_lsb;
  logic [11:0] issue_in;

  function automatic logic [3:0] lowest_set(input logic [7:0] bits);
    logic [3:0] r;
    r = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (bits[i] && !r[3]) r = {1'b1, 3'(i)};
    end
    return r;
  endfunction

  // svf_sel doubles as the current voice index; the search only looks above it.
  assign above = mask & ~((8'd2 << svf_sel) - 8'd1);
  assign {tick_found, tick_idx} = lowest_set(voice_en);
  assign {next_found, next_idx} = lowest_set(above);

  // The first voice of a frame is issued from voice_in directly, as the buffer loads on the same edge.
  assign issue_v   = start_frame ? tick_idx : next_idx;
  assign issue_lsb = 7'(issue_v) * 7'd12;
  assign issue_in  = start_frame ? voice_in[issue_lsb +: 12] : buffer[issue_lsb +: 12];

  assign cap_clr = (capture && svf_reset) ? (8'd1 << svf_sel) : '0;
  assign busy    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= (state == WAIT) ? wait_cnt + 2'd1 : '0;
    end
  end

  always_comb begin
    state_nxt   = state;
    start_frame = 1'b0;
    empty_frame = 1'b0;
    issue_next  = 1'b0;
    capture     = 1'b0;
    unique case (state)
      IDLE: begin
        if (sample_tick) begin
          if (tick_found) begin
            state_nxt   = ISSUE;
            start_frame = 1'b1;
          end else begin
            empty_frame = 1'b1;
          end
        end
      end
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        if (wait_cnt == 2'd2) state_nxt = CAPTURE;
      end
      CAPTURE: begin
        capture = 1'b1;
        if (next_found) begin
          state_nxt  = ISSUE;
          issue_next = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < 8; i++) begin
        tbl_f[i] <= '0;
        tbl_q[i] <= '0;
      end
    end else if (cfg_we) begin
      tbl_f[cfg_addr] <= cfg_f;
      tbl_q[cfg_addr] <= cfg_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      buffer <= '0;
      mask   <= '0;
    end else if (start_frame) begin
      buffer <= voice_in;
      mask   <= voice_en;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      svf_ena   <= 1'b0;
      svf_sel   <= '0;
      svf_f     <= '0;
      svf_q     <= '0;
      svf_in    <= '0;
      svf_reset <= 1'b0;
    end else begin
      svf_ena <= 1'b0;
      if (start_frame || issue_next) begin
        svf_ena   <= 1'b1;
        svf_sel   <= issue_v;
        svf_f     <= tbl_f[issue_v];
        svf_q     <= tbl_q[issue_v];
        svf_in    <= issue_in;
        svf_reset <= clear_pending[issue_v];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid  <= 1'b0;
      out_voice  <= '0;
      out_data   <= '0;
      frame_done <= 1'b0;
    end else begin
      out_valid  <= 1'b0;
      frame_done <= empty_frame;
      if (capture) begin
        out_valid  <= 1'b1;
        out_voice  <= svf_sel;
        out_data   <= svf_out;
        frame_done <= !next_found;
      end
    end
  end

  // A new clear request in the same cycle as a capture-clear keeps the bit pending.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      clear_pending <= '0;
      overrun       <= 1'b0;
    end else begin
      clear_pending <= (clear_pending & ~cap_clr) | (clear_stb ? clear_mask : '0);
      if (sample_tick && state != IDLE) overrun <= 1'b1;
      else if (overrun_clr)             overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_svf_voice_scheduler.sv
// Self-checking bench for svf_voice_scheduler: slot-schedule model checked every cycle,
// plus literal expectations at key frame cycles. A stub filter echoes svf_in sign-extended.
module tb_svf_voice_scheduler;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        sample_tick;
  logic [95:0] voice_in;
  logic [7:0]  voice_en;
  logic        cfg_we;
  logic [2:0]  cfg_addr;
  logic [17:0] cfg_f, cfg_q;
  logic        clear_stb;
  logic [7:0]  clear_mask;
  logic        overrun_clr;
  logic        svf_ena;
  logic [2:0]  svf_sel;
  logic [17:0] svf_f, svf_q;
  logic [11:0] svf_in;
  logic        svf_reset;
  logic [17:0] svf_out;
  logic        out_valid;
  logic [2:0]  out_voice;
  logic [17:0] out_data;
  logic        frame_done;
  logic        busy;
  logic        overrun;

  always #5 clk = ~clk;

  svf_voice_scheduler dut (
    .clk(clk), .reset_n(reset_n), .sample_tick(sample_tick),
    .voice_in(voice_in), .voice_en(voice_en),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_f(cfg_f), .cfg_q(cfg_q),
    .clear_stb(clear_stb), .clear_mask(clear_mask), .overrun_clr(overrun_clr),
    .svf_ena(svf_ena), .svf_sel(svf_sel), .svf_f(svf_f), .svf_q(svf_q),
    .svf_in(svf_in), .svf_reset(svf_reset), .svf_out(svf_out),
    .out_valid(out_valid), .out_voice(out_voice), .out_data(out_data),
    .frame_done(frame_done), .busy(busy), .overrun(overrun)
  );

  assign svf_out = {{6{svf_in[11]}}, svf_in};

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit chk_on = 1'b0;

  // Model state: table, pending clears, overrun, and the current frame as a voice list + start edge.
  logic [17:0] m_f [8];
  logic [17:0] m_q [8];
  logic [7:0]  m_cp;
  logic        m_ovr;
  logic [11:0] m_snap [8];
  int          m_list [$];
  bit          m_active;
  int          m_p;

  logic        e_ena, e_ov, e_fd, e_rst;
  logic [2:0]  e_sel, e_voice;
  logic [17:0] e_f, e_q, e_data;
  logic [11:0] e_in;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic issue(input int v);
    e_ena = 1'b1;
    e_sel = 3'(v);
    e_f   = m_f[v];
    e_q   = m_q[v];
    e_in  = m_snap[v];
    e_rst = m_cp[v];
  endtask

  always @(posedge clk) begin
    logic [7:0] clr;
    bit was_active;
    bit ovr_set;
    int k, i, v;
    cyc++;
    e_ena = 1'b0; e_ov = 1'b0; e_fd = 1'b0;
    clr = 8'h00; ovr_set = 1'b0;
    if (!reset_n) begin
      for (int n = 0; n < 8; n++) begin
        m_f[n] = '0; m_q[n] = '0; m_snap[n] = '0;
      end
      m_cp = '0; m_ovr = 1'b0; m_active = 1'b0; m_list.delete();
      e_sel = '0; e_f = '0; e_q = '0; e_in = '0; e_rst = 1'b0;
      e_voice = '0; e_data = '0;
    end else begin
      was_active = m_active;
      if (m_active) begin
        k = cyc - m_p;
        if (k % 5 == 0) begin
          i = k / 5;
          if (i >= 1) begin
            v = m_list[i-1];
            e_ov = 1'b1;
            e_voice = 3'(v);
            e_data = {{6{m_snap[v][11]}}, m_snap[v]};
            if (e_rst) clr[v] = 1'b1;
            if (i == m_list.size()) begin
              e_fd = 1'b1;
              m_active = 1'b0;
            end
          end
          if (i < m_list.size()) issue(m_list[i]);
        end
      end
      if (sample_tick) begin
        if (was_active) ovr_set = 1'b1;
        else begin
          m_list.delete();
          for (int n = 0; n < 8; n++) begin
            m_snap[n] = voice_in[12*n +: 12];
            if (voice_en[n]) m_list.push_back(n);
          end
          if (m_list.size() == 0) e_fd = 1'b1;
          else begin
            m_active = 1'b1;
            m_p = cyc;
            issue(m_list[0]);
          end
        end
      end
      m_cp = (m_cp & ~clr) | (clear_stb ? clear_mask : 8'h00);
      if (cfg_we) begin
        m_f[cfg_addr] = cfg_f;
        m_q[cfg_addr] = cfg_q;
      end
      if (ovr_set) m_ovr = 1'b1;
      else if (overrun_clr) m_ovr = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("svf_ena", svf_ena, e_ena);
      chk("svf_sel", svf_sel, e_sel);
      chk("svf_f", svf_f, e_f);
      chk("svf_q", svf_q, e_q);
      chk("svf_in", svf_in, e_in);
      chk("svf_reset", svf_reset, e_rst);
      chk("out_valid", out_valid, e_ov);
      chk("out_voice", out_voice, e_voice);
      chk("out_data", out_data, e_data);
      chk("frame_done", frame_done, e_fd);
      chk("busy", busy, m_active);
      chk("overrun", overrun, m_ovr);
    end
  end

  task automatic wait_rel(input int p, input int r);
    while (cyc < p + r - 1) @(negedge clk);
  endtask

  task automatic start(output int p);
    p = cyc + 1;
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic [17:0] f, input logic [17:0] q);
    cfg_we = 1'b1; cfg_addr = a; cfg_f = f; cfg_q = q;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic pulse_clear(input logic [7:0] m);
    clear_stb = 1'b1; clear_mask = m;
    @(negedge clk);
    clear_stb = 1'b0; clear_mask = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int pa, pb, pc, pd, pe, pf, pg, ph, pi;
    reset_n = 1'b0; sample_tick = 1'b0; voice_in = '0; voice_en = '0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_f = '0; cfg_q = '0;
    clear_stb = 1'b0; clear_mask = '0; overrun_clr = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk_on = 1'b1;
    chk("pin_reset_busy", busy, 1'b0);
    chk("pin_reset_sel", svf_sel, 3'd0);

    // Frame A: all voices, f=q=0, voice_in v = 100*v
    for (int v = 0; v < 8; v++) voice_in[12*v +: 12] = 12'(100 * v);
    voice_en = 8'hFF;
    start(pa);
    chk("pin_A_ena", svf_ena, 1'b1);
    chk("pin_A_sel", svf_sel, 3'd0);
    wait_rel(pa, 11);
    chk("pin_A_ov11", out_valid, 1'b1);
    chk("pin_A_voice11", out_voice, 3'd1);
    chk("pin_A_data11", out_data, 18'd100);
    wait_rel(pa, 20);
    sample_tick = 1'b1; @(negedge clk); sample_tick = 1'b0;
    chk("pin_A_overrun", overrun, 1'b1);
    wait_rel(pa, 37);
    cfg_write(3'd0, 18'd1000, 18'd11);
    cfg_write(3'd5, 18'h3F830, 18'd22);
    cfg_write(3'd7, 18'd3000, 18'd33);
    wait_rel(pa, 41);
    chk("pin_A_fd41", frame_done, 1'b1);
    chk("pin_A_voice41", out_voice, 3'd7);
    chk("pin_A_data41", out_data, 18'd700);
    chk("pin_A_busy41", busy, 1'b0);

    // Frame B: voices 0,5,7 only; tick at cycle 41 of frame A
    voice_in[0 +: 12]  = 12'hFFB;
    voice_in[60 +: 12] = 12'h7FF;
    voice_in[84 +: 12] = 12'h800;
    voice_en = 8'b1010_0001;
    start(pb);
    chk("pin_B_busy", busy, 1'b1);
    chk("pin_B_f0", svf_f, 18'd1000);
    chk("pin_B_in0", svf_in, 12'hFFB);
    @(negedge clk);
    voice_in = {8{12'h555}};
    wait_rel(pb, 6);
    chk("pin_B_sel5", svf_sel, 3'd5);
    chk("pin_B_f5", svf_f, 18'h3F830);
    chk("pin_B_data0", out_data, 18'h3FFFB);
    wait_rel(pb, 8);
    overrun_clr = 1'b1; sample_tick = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0; sample_tick = 1'b0;
    chk("pin_B_ovr_set_wins", overrun, 1'b1);
    wait_rel(pb, 10);
    overrun_clr = 1'b1; @(negedge clk); overrun_clr = 1'b0;
    chk("pin_B_ovr_clr", overrun, 1'b0);
    chk("pin_B_sel7", svf_sel, 3'd7);
    chk("pin_B_q7", svf_q, 18'd33);
    wait_rel(pb, 16);
    chk("pin_B_fd16", frame_done, 1'b1);
    chk("pin_B_data7", out_data, 18'h3F800);

    // Frame C: voice 2 disabled with a clear pending; voice 3 rewritten during its WAIT
    cfg_write(3'd3, 18'd555, 18'd66);
    pulse_clear(8'h04);
    for (int v = 0; v < 8; v++) voice_in[12*v +: 12] = 12'(10 * v + 1);
    voice_en = 8'hFB;
    start(pc);
    wait_rel(pc, 11);
    chk("pin_C_sel3", svf_sel, 3'd3);
    chk("pin_C_f3", svf_f, 18'd555);
    wait_rel(pc, 12);
    cfg_write(3'd3, 18'd12345, 18'h3FFF9);
    chk("pin_C_f3_held", svf_f, 18'd555);
    chk("pin_C_q3_held", svf_q, 18'd66);
    wait_rel(pc, 36);
    chk("pin_C_fd36", frame_done, 1'b1);

    // Frame D: voice 2 gets its clear; a new clear arrives on its capture edge
    voice_en = 8'hFF;
    start(pd);
    wait_rel(pd, 11);
    chk("pin_D_sel2", svf_sel, 3'd2);
    chk("pin_D_rst2", svf_reset, 1'b1);
    wait_rel(pd, 15);
    pulse_clear(8'h04);
    chk("pin_D_f3_new", svf_f, 18'd12345);
    chk("pin_D_rst3", svf_reset, 1'b0);
    wait_rel(pd, 41);

    // Frames E/F: single voice 2, pending kept then consumed
    voice_en = 8'h04;
    start(pe);
    chk("pin_E_rst2", svf_reset, 1'b1);
    wait_rel(pe, 6);
    chk("pin_E_fd6", frame_done, 1'b1);
    chk("pin_E_data", out_data, 18'd21);
    start(pf);
    chk("pin_F_rst2", svf_reset, 1'b0);
    wait_rel(pf, 6);

    // Frame G: empty mask
    voice_en = 8'h00;
    start(pg);
    chk("pin_G_fd", frame_done, 1'b1);
    chk("pin_G_ov", out_valid, 1'b0);
    chk("pin_G_busy", busy, 1'b0);

    // Frame H: reset mid-frame, then a clean restart
    voice_en = 8'hFF;
    start(ph);
    wait_rel(ph, 12);
    reset_n = 1'b0; @(negedge clk); reset_n = 1'b1;
    chk("pin_H_busy", busy, 1'b0);
    chk("pin_H_ena", svf_ena, 1'b0);
    chk("pin_H_f", svf_f, 18'd0);
    chk("pin_H_sel", svf_sel, 3'd0);
    chk("pin_H_in", svf_in, 12'd0);
    chk("pin_H_data", out_data, 18'd0);
    start(pi);
    chk("pin_I_ena", svf_ena, 1'b1);
    chk("pin_I_sel", svf_sel, 3'd0);
    chk("pin_I_f0", svf_f, 18'd0);
    chk("pin_I_in0", svf_in, 12'd1);
    wait_rel(pi, 41);
    chk("pin_I_fd41", frame_done, 1'b1);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
